io_responder: RTL and testbench

IO_RESPONDER -- requirements
Module: io_responder

---
 rtl/io_responder_pkg.sv | 28 ++
 rtl/io_fifo.sv | 52 +++++
 rtl/io_responder.sv | 164 ++++++++++++++++
 tb/tb_io_responder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_responder_pkg.sv
// Shared definitions for the io_responder register block: offsets, STATUS bit
// positions, FSM encoding and the captured request record.
package io_responder_pkg;

    localparam logic [2:0] OFF_TXDATA  = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_TLOAD   = 3'd2;
    localparam logic [2:0] OFF_TCOUNT  = 3'd3;
    localparam logic [2:0] OFF_SCRATCH = 3'd4;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EXPIRED = 2;
    localparam int ST_RUNNING = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic       write;
        logic [2:0] off;
        logic [7:0] wdata;
    } req_t;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with occupancy count; pushes into a full FIFO and pops
// from an empty one are ignored. Head reads as zero while empty.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/io_responder.sv
// Bus responder exposing an 8-byte register window: TX FIFO, status, a
// down-counting timer and a scratch register. One transaction in flight.
module io_responder
    import io_responder_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hF0,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_valid_i,
    input  logic       req_write_i,
    input  logic [7:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       req_ready_o,
    output logic       resp_valid_o,
    input  logic       resp_ready_i,
    output logic [7:0] resp_rdata_o,
    output logic       resp_err_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    req_t          req_q, req_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic [7:0]    scratch_q, scratch_d;
    logic          fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [7:0]    fifo_head;
    logic          in_win, accept, stat_rd, load_wr;

    assign in_win       = (req_addr_i[7:3] == BASE_ADDR[7:3]);
    // Reset gates ready: the FSM already sits in IDLE while reset is held.
    assign req_ready_o  = ~reset_i & (state_q == S_IDLE) & in_win;
    assign accept       = req_valid_i & req_ready_o;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign out_valid_o  = ~fifo_empty;
    assign out_data_o   = fifo_head;

    io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (reset_i),
        .push_i  (fifo_push),
        .data_i  (req_q.wdata),
        .pop_i   (out_valid_o & out_ready_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        scratch_d = scratch_q;
        fifo_push = 1'b0;
        stat_rd   = 1'b0;
        load_wr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_d   = '{write: req_write_i, off: req_addr_i[2:0], wdata: req_wdata_i};
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                rdata_d = '0;
                err_d   = 1'b0;
                case (req_q.off)
                    OFF_TXDATA: begin
                        // Drop decision looks at occupancy only, not a same-cycle pop.
                        if (!req_q.write)                         err_d = 1'b1;
                        else if (fifo_cnt == CW'(FIFO_DEPTH))     err_d = 1'b1;
                        else                                      fifo_push = 1'b1;
                    end
                    OFF_STATUS: begin
                        if (req_q.write) err_d = 1'b1;
                        else begin
                            rdata_d[ST_RUNNING] = running_q;
                            rdata_d[ST_EXPIRED] = expired_q;
                            rdata_d[ST_FULL]    = fifo_full;
                            rdata_d[ST_EMPTY]   = fifo_empty;
                            stat_rd             = 1'b1;
                        end
                    end
                    OFF_TLOAD: begin
                        if (req_q.write) load_wr = 1'b1;
                        else             err_d   = 1'b1;
                    end
                    OFF_TCOUNT: begin
                        if (req_q.write) err_d   = 1'b1;
                        else             rdata_d = cnt_q;
                    end
                    OFF_SCRATCH: begin
                        if (req_q.write) scratch_d = req_q.wdata;
                        else             rdata_d   = scratch_q;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            S_RESP: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timer: a load wins over everything; otherwise expiry is applied after the
    // STATUS-read clear so a coincident expiry keeps the sticky flag set.
    always_comb begin
        cnt_d     = cnt_q;
        running_d = running_q;
        expired_d = expired_q;
        if (load_wr) begin
            cnt_d     = req_q.wdata;
            running_d = (req_q.wdata != 8'd0);
            expired_d = (req_q.wdata == 8'd0);
        end else begin
            if (stat_rd) expired_d = 1'b0;
            if (running_q) begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    running_d = 1'b0;
                    expired_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            scratch_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            expired_q <= expired_d;
            scratch_q <= scratch_d;
        end
    end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: directed scenarios plus a randomized
// mix scored against a transaction/edge-indexed reference model.
module tb_io_responder;
    localparam int         DEPTH = 4;
    localparam logic [7:0] BASE  = 8'hF0;

    logic       clk = 1'b0, reset = 1'b0;
    logic       req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0, out_ready = 1'b0;
    logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
    logic       req_ready, resp_valid, resp_err, out_valid;
    logic [7:0] resp_rdata, out_data;

    int n_chk = 0, n_pass = 0, cyc = 0;

    // Reference model state; timer history is kept as edge numbers.
    logic [7:0] mq[$];
    logic [7:0] m_scr = 8'h00;
    int         ld_edge = -1, ld_n = 0, exp_edge = -1, clr_edge = -1;
    logic [7:0] m_rd;
    logic       m_err;
    bit         rand_pop = 1'b0;

    io_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_ready_o(req_ready),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] m_count(input int k);
        int v;
        if (ld_edge < 0) return 8'h00;
        v = ld_n - (k - ld_edge);
        if (v < 0) v = 0;
        return 8'(v);
    endfunction

    function automatic bit m_running(input int k);
        return (ld_edge >= 0) && (ld_n > 0) && (k < ld_edge + ld_n);
    endfunction

    function automatic bit m_expired(input int k);
        return (exp_edge >= 0) && (exp_edge <= k) && !(clr_edge > exp_edge && clr_edge <= k);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_scr = 8'h00; ld_edge = -1; ld_n = 0; exp_edge = -1; clr_edge = -1;
    endtask

    // Register access taking effect at edge k, seeing state left by edge k-1.
    task automatic model_access(input int k, input bit w, input logic [7:0] a,
                                input logic [7:0] d, input int sz0);
        logic [7:0] off;
        off = a - BASE;
        m_rd = 8'h00; m_err = 1'b0;
        case (off)
            8'd0: if (w) begin if (sz0 == DEPTH) m_err = 1'b1; else mq.push_back(d); end
                  else m_err = 1'b1;
            8'd1: if (!w) begin
                      m_rd = {4'b0, m_running(k-1), m_expired(k-1), sz0 == DEPTH, sz0 == 0};
                      clr_edge = k;
                  end else m_err = 1'b1;
            8'd2: if (w) begin ld_edge = k; ld_n = int'(d); exp_edge = k + int'(d); end
                  else m_err = 1'b1;
            8'd3: if (!w) m_rd = m_count(k-1); else m_err = 1'b1;
            8'd4: if (w) m_scr = d; else m_rd = m_scr;
            default: m_err = 1'b1;
        endcase
    endtask

    // Advance one clock from a falling edge to the next, updating the model for
    // the rising edge in between.
    task automatic tick(input bit acc = 1'b0, input bit w = 1'b0,
                        input logic [7:0] a = 8'h00, input logic [7:0] d = 8'h00);
        int k, sz0;
        if (rand_pop) out_ready = 1'($urandom_range(0, 1));
        k = cyc + 1;
        sz0 = mq.size();
        if (!reset) begin
            if (out_ready && sz0 > 0) void'(mq.pop_front());
            if (acc) model_access(k, w, a, d, sz0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // One full bus transaction; ok reports handshake timing and response stability.
    task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d, input int hold,
                          output logic [7:0] rd, output logic er, output bit ok);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        #1;
        n = 0;
        while (req_ready !== 1'b1 && n < 8) begin tick(); #1; n++; end
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0; rd = 8'h00; er = 1'b0; ok = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        #1 ok = (resp_valid === 1'b0);
        tick(1'b1, w, a, d);
        #1 ok &= (resp_valid === 1'b1);
        rd = resp_rdata; er = resp_err;
        repeat (hold) begin
            tick();
            #1 ok &= (resp_valid === 1'b1 && resp_rdata === rd && resp_err === er);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        #1 ok &= (resp_valid === 1'b0);
    endtask

    task automatic test_reset();
        #1 reset = 1'b1; req_valid = 1'b1; req_addr = BASE;
        #1;
        n_chk++; if (req_ready !== 1'b0)  $display("FAIL rst_req_ready: got %b want 0", req_ready);  else n_pass++;
        n_chk++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_chk++; if (resp_rdata !== 8'h00) $display("FAIL rst_resp_rdata: got %h want 00", resp_rdata); else n_pass++;
        n_chk++; if (resp_err !== 1'b0)   $display("FAIL rst_resp_err: got %b want 0", resp_err);   else n_pass++;
        n_chk++; if (out_valid !== 1'b0)  $display("FAIL rst_out_valid: got %b want 0", out_valid);  else n_pass++;
        n_chk++; if (out_data !== 8'h00)  $display("FAIL rst_out_data: got %h want 00", out_data);   else n_pass++;
        @(negedge clk);
        tick(); tick();
        reset = 1'b0; req_valid = 1'b0;
        model_reset();
        #1;
        n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", req_ready); else n_pass++;
        tick();
    endtask

    task automatic test_scratch();
        logic [7:0] rd; logic er; bit ok;
        do_req(1'b1, BASE + 8'd4, 8'hA5, 0, rd, er, ok);
        n_chk++; if (!ok || er !== 1'b0 || rd !== 8'h00)
            $display("FAIL scratch_wr: ok=%0d err=%b rdata=%h want ok=1 err=0 rdata=00", ok, er, rd); else n_pass++;
        do_req(1'b0, BASE + 8'd4, 8'h00, 2, rd, er, ok);
        n_chk++; if (!ok) $display("FAIL scratch_rd_timing: handshake/stability bad, want valid 2 cycles after accept"); else n_pass++;
        n_chk++; if (rd !== 8'hA5 || er !== 1'b0)
            $display("FAIL scratch_rd: got rdata=%h err=%b want A5/0", rd, er); else n_pass++;
    endtask

    task automatic test_fifo_full();
        logic [7:0] rd; logic er; bit ok;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            do_req(1'b1, BASE, 8'(i), 0, rd, er, ok);
            n_chk++; if (!ok || er !== (i == 5) || rd !== 8'h00)
                $display("FAIL fifo_push%0d: ok=%0d err=%b rdata=%h want err=%0d", i, ok, er, rd, (i == 5)); else n_pass++;
        end
        do_req(1'b0, BASE + 8'd1, 8'h00, 0, rd, er, ok);
        n_chk++; if (!ok || rd !== 8'h02 || er !== 1'b0)
            $display("FAIL fifo_status: got %h err=%b want 02/0", rd, er); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_chk++; if (out_valid !== 1'b1 || out_data !== 8'(i))
                $display("FAIL fifo_drain%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(i)); else n_pass++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        #1;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL fifo_empty: out_valid=%b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_timer();
        logic [7:0] rd; logic er; bit ok;
        logic [7:0] exp_st[3];
        logic [7:0] exp_cnt[3];
        exp_st = '{8'h09, 8'h05, 8'h01};
        exp_cnt = '{8'd8, 8'd5, 8'd2};
        // Load 3: first read lands on the expiry edge, so the flag must survive it.
        do_req(1'b1, BASE + 8'd2, 8'd3, 0, rd, er, ok);
        n_chk++; if (!ok || er !== 1'b0) $display("FAIL tload3: ok=%0d err=%b want 1/0", ok, er); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, BASE + 8'd1, 8'h00, 0, rd, er, ok);
            n_chk++; if (!ok || rd !== exp_st[i] || er !== 1'b0)
                $display("FAIL timer_status%0d: got %h want %h", i, rd, exp_st[i]); else n_pass++;
        end
        do_req(1'b1, BASE + 8'd2, 8'd10, 0, rd, er, ok);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, BASE + 8'd3, 8'h00, 0, rd, er, ok);
            n_chk++; if (!ok || rd !== exp_cnt[i])
                $display("FAIL timer_count%0d: got %0d want %0d", i, rd, exp_cnt[i]); else n_pass++;
        end
        do_req(1'b1, BASE + 8'd2, 8'd5, 0, rd, er, ok);
        do_req(1'b0, BASE + 8'd3, 8'h00, 0, rd, er, ok);
        n_chk++; if (rd !== 8'd3) $display("FAIL timer_restart: got %0d want 3", rd); else n_pass++;
        do_req(1'b1, BASE + 8'd2, 8'd0, 0, rd, er, ok);
        do_req(1'b0, BASE + 8'd1, 8'h00, 0, rd, er, ok);
        n_chk++; if (rd !== 8'h05) $display("FAIL timer_load0: got %h want 05", rd); else n_pass++;
        do_req(1'b0, BASE + 8'd1, 8'h00, 0, rd, er, ok);
        n_chk++; if (rd !== 8'h01) $display("FAIL timer_cleared: got %h want 01", rd); else n_pass++;
    endtask

    task automatic test_bad_access();
        logic [7:0] rd; logic er; bit ok;
        logic [7:0] bad_a[6];
        bit         bad_w[6];
        bad_a = '{8'hF6, 8'hF0, 8'hF1, 8'hF3, 8'hF2, 8'hF7};
        bad_w = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_req(1'b1, BASE + 8'd4, 8'h3C, 0, rd, er, ok);
        for (int i = 0; i < 6; i++) begin
            do_req(bad_w[i], bad_a[i], 8'hFF, 0, rd, er, ok);
            n_chk++; if (!ok || er !== 1'b1 || rd !== 8'h00)
                $display("FAIL bad_access %h w=%0d: err=%b rdata=%h want 1/00", bad_a[i], bad_w[i], er, rd); else n_pass++;
        end
        do_req(1'b0, BASE + 8'd4, 8'h00, 0, rd, er, ok);
        n_chk++; if (rd !== 8'h3C) $display("FAIL bad_scratch_kept: got %h want 3C", rd); else n_pass++;
        do_req(1'b0, BASE + 8'd1, 8'h00, 0, rd, er, ok);
        n_chk++; if (rd !== 8'h01) $display("FAIL bad_status_kept: got %h want 01", rd); else n_pass++;
    endtask

    task automatic test_out_of_window();
        logic [7:0] edges[3];
        logic       want[3];
        edges = '{8'hEF, 8'hF8, 8'hF7};
        want = '{1'b0, 1'b0, 1'b1};
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h55;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_chk++; if (req_ready !== 1'b0 || resp_valid !== 1'b0)
                $display("FAIL oow_cycle%0d: ready=%b resp_valid=%b want 0/0", i, req_ready, resp_valid); else n_pass++;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            req_addr = edges[i];
            #1;
            n_chk++; if (req_ready !== want[i])
                $display("FAIL window_edge %h: ready=%b want %b", edges[i], req_ready, want[i]); else n_pass++;
        end
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] rd, a, d; logic er; bit ok, w;
        rand_pop = 1'b1;
        for (int i = 0; i < 60; i++) begin
            a = BASE + 8'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            d = (a == BASE + 8'd2) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            do_req(w, a, d, $urandom_range(0, 2), rd, er, ok);
            n_chk++; if (!ok || rd !== m_rd || er !== m_err)
                $display("FAIL rand%0d a=%h w=%0d: ok=%0d rdata=%h err=%b want %h/%b", i, a, w, ok, rd, er, m_rd, m_err); else n_pass++;
            n_chk++; if (out_valid !== (mq.size() > 0) || (mq.size() > 0 && out_data !== mq[0]))
                $display("FAIL rand_out%0d: valid=%b data=%h want %b/%h", i, out_valid, out_data,
                         (mq.size() > 0), (mq.size() > 0) ? mq[0] : 8'h00); else n_pass++;
        end
        rand_pop = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_in_resp();
        logic [7:0] rd; logic er; bit ok;
        out_ready = 1'b1;
        repeat (DEPTH) tick();
        out_ready = 1'b0;
        do_req(1'b1, BASE + 8'd4, 8'h5A, 0, rd, er, ok);
        do_req(1'b1, BASE, 8'h77, 0, rd, er, ok);
        req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 8'd4;
        #1 tick();
        req_valid = 1'b0;
        tick(1'b1, 1'b0, BASE + 8'd4, 8'h00);
        #1;
        n_chk++; if (resp_valid !== 1'b1) $display("FAIL rresp_pre: resp_valid=%b want 1", resp_valid); else n_pass++;
        #1 reset = 1'b1; req_valid = 1'b1; req_addr = BASE;
        #1;
        n_chk++; if (resp_valid !== 1'b0 || resp_rdata !== 8'h00 || resp_err !== 1'b0)
            $display("FAIL rresp_abort: valid=%b rdata=%h err=%b want 0/00/0", resp_valid, resp_rdata, resp_err); else n_pass++;
        n_chk++; if (out_valid !== 1'b0 || out_data !== 8'h00 || req_ready !== 1'b0)
            $display("FAIL rresp_outs: out_valid=%b out_data=%h ready=%b want 0/00/0", out_valid, out_data, req_ready); else n_pass++;
        model_reset();
        tick(); tick();
        reset = 1'b0; req_valid = 1'b0;
        #1;
        n_chk++; if (resp_valid !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL rresp_release: resp_valid=%b out_valid=%b want 0/0", resp_valid, out_valid); else n_pass++;
        do_req(1'b0, BASE + 8'd1, 8'h00, 0, rd, er, ok);
        n_chk++; if (!ok || rd !== 8'h01) $display("FAIL rresp_status: got %h want 01", rd); else n_pass++;
        do_req(1'b0, BASE + 8'd4, 8'h00, 0, rd, er, ok);
        n_chk++; if (!ok || rd !== 8'h00) $display("FAIL rresp_scratch: got %h want 00", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_fifo_full();
        test_timer();
        test_bad_access();
        test_out_of_window();
        test_random();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
